// File: rtl/seq_stage_controller.sv
// Multi-cycle Y86-64 SEQ sequencer: owns the architectural PC, steps one stage per cycle with
// one-hot enables, waits on the data-memory handshake with a timeout, and tracks Y86 status.
module seq_stage_controller #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          MAX_INSTR   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_mode,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        mem_done,
    input  logic        dmem_error,
    input  logic [63:0] nPC,
    output logic [63:0] PC,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        writeback_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic        halted,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int             WW        = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'(MEM_TIMEOUT - 1);
    // Divisor forced non-zero so the modulo stays well defined when the budget is disabled.
    localparam logic [31:0]    MAX_DIV   = (MAX_INSTR == 0) ? 32'd1 : 32'(MAX_INSTR);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [2:0]    next_stat;
    logic [3:0]    icode_q;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   count_inc;
    logic          budget_hit;

    function automatic logic is_mem_class(input logic [3:0] code);
        case (code)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_class = 1'b1;
            default:                             is_mem_class = 1'b0;
        endcase
    endfunction

    always_comb begin
        count_inc  = (instr_count == 32'hFFFF_FFFF) ? instr_count : instr_count + 32'd1;
        budget_hit = (MAX_INSTR != 0) && ((count_inc % MAX_DIV) == 32'd0);
    end

    always_comb begin
        next_state = state;
        next_stat  = stat;
        case (state)
            S_IDLE: if (start) next_state = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    next_stat  = STAT_ADR;
                    next_state = S_HALT;
                end else if (!instr_valid) begin
                    next_stat  = STAT_INS;
                    next_state = S_HALT;
                end else begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE:  next_state = S_EXECUTE;
            S_EXECUTE: next_state = S_MEMORY;
            S_MEMORY: begin
                // A mem_done arriving on the last allowed cycle is checked first and wins.
                if (!is_mem_class(icode_q)) begin
                    next_state = S_WRITEBACK;
                end else if (mem_done) begin
                    if (dmem_error) begin
                        next_stat  = STAT_ADR;
                        next_state = S_HALT;
                    end else begin
                        next_state = S_WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    next_stat  = STAT_ADR;
                    next_state = S_HALT;
                end
            end
            S_WRITEBACK: next_state = S_PCUPD;
            S_PCUPD: begin
                if (icode_q == 4'h0) begin
                    next_stat  = STAT_HLT;
                    next_state = S_HALT;
                end else if (step_mode || budget_hit) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every enable is a clean flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            PC           <= RESET_PC;
            stat         <= STAT_AOK;
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            execute_en   <= 1'b0;
            memory_en    <= 1'b0;
            writeback_en <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            instr_count  <= 32'd0;
            cycle_count  <= 32'd0;
            icode_q      <= 4'h0;
            wait_cnt     <= '0;
        end else begin
            state        <= next_state;
            stat         <= next_stat;
            fetch_en     <= (next_state == S_FETCH);
            decode_en    <= (next_state == S_DECODE);
            execute_en   <= (next_state == S_EXECUTE);
            memory_en    <= (next_state == S_MEMORY);
            writeback_en <= (next_state == S_WRITEBACK);
            busy         <= (next_state != S_IDLE) && (next_state != S_HALT);
            halted       <= (next_state == S_HALT);
            if (state == S_FETCH) icode_q <= icode;
            if (state == S_EXECUTE) wait_cnt <= '0;
            else if (state == S_MEMORY) wait_cnt <= wait_cnt + WW'(1);
            if (state == S_PCUPD) begin
                PC          <= nPC;
                instr_count <= count_inc;
            end
            if (busy && (cycle_count != 32'hFFFF_FFFF)) cycle_count <= cycle_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller: walks normal, memory-wait, timeout, halt, fault,
// step-mode and async-reset scenarios with hand-computed expectations.
module tb_seq_stage_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        instr_valid = 1'b0;
    logic        imem_error = 1'b0;
    logic        mem_done = 1'b0;
    logic        dmem_error = 1'b0;
    logic [63:0] nPC = 64'd0;
    logic [63:0] PC;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en;
    logic [2:0]  stat;
    logic        busy, halted;
    logic [31:0] instr_count, cycle_count;
    logic [4:0]  en;

    int total = 0;
    int bad   = 0;
    int n;

    seq_stage_controller #(.RESET_PC(64'h100), .MEM_TIMEOUT(16), .MAX_INSTR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error), .mem_done(mem_done),
        .dmem_error(dmem_error), .nPC(nPC), .PC(PC), .fetch_en(fetch_en),
        .decode_en(decode_en), .execute_en(execute_en), .memory_en(memory_en),
        .writeback_en(writeback_en), .stat(stat), .busy(busy), .halted(halted),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    assign en = {fetch_en, decode_en, execute_en, memory_en, writeback_en};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] ic, input logic iv, input logic ie,
                                 input logic [63:0] npc);
        icode       = ic;
        instr_valid = iv;
        imem_error  = ie;
        nPC         = npc;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        $display("[TB] starting seq_stage_controller bench");
        doReset();
        checkOutput("reset_pc", PC, 64'h100);
        checkOutput("reset_en", {59'd0, en}, 64'd0);
        checkOutput("reset_stat", {61'd0, stat}, 64'd1);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_halted", {63'd0, halted}, 64'd0);
        checkOutput("reset_icount", {32'd0, instr_count}, 64'd0);

        // Non-memory instruction, six cycles, stage enables in order.
        applyStimulus(4'h6, 1'b1, 1'b0, 64'd2);
        pulseStart();
        checkOutput("t1_fetch", {59'd0, en}, 64'b10000);
        checkOutput("t1_busy", {63'd0, busy}, 64'd1);
        tick(); checkOutput("t1_decode", {59'd0, en}, 64'b01000);
        tick(); checkOutput("t1_execute", {59'd0, en}, 64'b00100);
        tick(); checkOutput("t1_memory", {59'd0, en}, 64'b00010);
        tick(); checkOutput("t1_writeback", {59'd0, en}, 64'b00001);
        tick(); checkOutput("t1_pcupd_en", {59'd0, en}, 64'd0);
        checkOutput("t1_pc_before", PC, 64'h100);
        tick(); checkOutput("t1_refetch", {59'd0, en}, 64'b10000);
        checkOutput("t1_pc", PC, 64'd2);
        checkOutput("t1_icount", {32'd0, instr_count}, 64'd1);
        checkOutput("t1_ccount", {32'd0, cycle_count}, 64'd6);

        // Memory-class instruction with mem_done after three waiting cycles.
        applyStimulus(4'h5, 1'b1, 1'b0, 64'd3);
        tick(); tick(); tick();
        checkOutput("t2_mem1", {63'd0, memory_en}, 64'd1);
        tick(); checkOutput("t2_mem2", {63'd0, memory_en}, 64'd1);
        tick(); checkOutput("t2_mem3", {63'd0, memory_en}, 64'd1);
        tick(); checkOutput("t2_mem4", {63'd0, memory_en}, 64'd1);
        mem_done = 1'b1;
        tick(); checkOutput("t2_writeback", {59'd0, en}, 64'b00001);
        mem_done = 1'b0;
        tick(); tick();
        checkOutput("t2_refetch", {63'd0, fetch_en}, 64'd1);
        checkOutput("t2_pc", PC, 64'd3);
        checkOutput("t2_icount", {32'd0, instr_count}, 64'd2);
        checkOutput("t2_stat", {61'd0, stat}, 64'd1);
        checkOutput("t2_ccount", {32'd0, cycle_count}, 64'd15);

        // Memory-class instruction that never completes: timeout after 16 MEMORY cycles.
        applyStimulus(4'hA, 1'b1, 1'b0, 64'd4);
        tick(); tick(); tick();
        n = 0;
        while (memory_en && n < 40) begin
            n++;
            tick();
        end
        checkOutput("t3_mem_cycles", 64'(n), 64'd16);
        checkOutput("t3_stat", {61'd0, stat}, 64'd3);
        checkOutput("t3_halted", {63'd0, halted}, 64'd1);
        checkOutput("t3_pc", PC, 64'd3);
        checkOutput("t3_icount", {32'd0, instr_count}, 64'd2);
        pulseStart();
        tick();
        checkOutput("t3_halt_sticky", {59'd0, en}, 64'd0);
        checkOutput("t3_halt_busy", {63'd0, busy}, 64'd0);

        // mem_done on the final allowed cycle beats the timeout.
        doReset();
        applyStimulus(4'hB, 1'b1, 1'b0, 64'd5);
        pulseStart();
        tick(); tick(); tick();
        repeat (15) tick();
        checkOutput("t4_mem16", {63'd0, memory_en}, 64'd1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        checkOutput("t4_writeback", {59'd0, en}, 64'b00001);
        checkOutput("t4_stat", {61'd0, stat}, 64'd1);

        // Data-memory error reported with mem_done.
        doReset();
        applyStimulus(4'h4, 1'b1, 1'b0, 64'd20);
        mem_done = 1'b1;
        dmem_error = 1'b1;
        pulseStart();
        tick(); tick(); tick(); tick();
        mem_done = 1'b0;
        dmem_error = 1'b0;
        checkOutput("t5_stat", {61'd0, stat}, 64'd3);
        checkOutput("t5_halted", {63'd0, halted}, 64'd1);
        checkOutput("t5_pc", PC, 64'h100);

        // Halt instruction: PC advances to nPC, status HLT, start then ignored.
        doReset();
        applyStimulus(4'h0, 1'b1, 1'b0, 64'd1);
        pulseStart();
        repeat (6) tick();
        checkOutput("t6_stat", {61'd0, stat}, 64'd2);
        checkOutput("t6_halted", {63'd0, halted}, 64'd1);
        checkOutput("t6_pc", PC, 64'd1);
        checkOutput("t6_icount", {32'd0, instr_count}, 64'd1);
        pulseStart();
        checkOutput("t6_no_enable", {59'd0, en}, 64'd0);
        checkOutput("t6_ccount", {32'd0, cycle_count}, 64'd6);

        // Illegal instruction, then imem_error taking priority over instr_valid.
        doReset();
        applyStimulus(4'h6, 1'b0, 1'b0, 64'd9);
        pulseStart();
        tick();
        checkOutput("t7_ins_stat", {61'd0, stat}, 64'd4);
        checkOutput("t7_ins_decode", {63'd0, decode_en}, 64'd0);
        checkOutput("t7_ins_pc", PC, 64'h100);
        doReset();
        applyStimulus(4'h6, 1'b0, 1'b1, 64'd9);
        pulseStart();
        tick();
        checkOutput("t7_adr_stat", {61'd0, stat}, 64'd3);
        checkOutput("t7_adr_halted", {63'd0, halted}, 64'd1);

        // Step mode: one instruction then IDLE, next start runs another; reset mid-EXECUTE.
        doReset();
        step_mode = 1'b1;
        applyStimulus(4'h6, 1'b1, 1'b0, 64'd8);
        pulseStart();
        repeat (6) tick();
        checkOutput("t8_busy", {63'd0, busy}, 64'd0);
        checkOutput("t8_en", {59'd0, en}, 64'd0);
        checkOutput("t8_pc", PC, 64'd8);
        checkOutput("t8_icount", {32'd0, instr_count}, 64'd1);
        tick();
        checkOutput("t8_stays_idle", {63'd0, fetch_en}, 64'd0);
        applyStimulus(4'h6, 1'b1, 1'b0, 64'h10);
        pulseStart();
        checkOutput("t8_restart", {63'd0, fetch_en}, 64'd1);
        tick(); tick();
        checkOutput("t8_execute", {63'd0, execute_en}, 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t8_rst_pc", PC, 64'h100);
        checkOutput("t8_rst_en", {59'd0, en}, 64'd0);
        checkOutput("t8_rst_icount", {32'd0, instr_count}, 64'd0);
        checkOutput("t8_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        rst = 1'b0;
        step_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
